// File: rtl/decode_issue_ctrl_pkg.sv
// Shared MIPS decode constants (opcodes, functs, REGIMM rt codes, memory widths)
// and the ID/EX control-bundle layout used by the decoder and the issue stage.
package decode_issue_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE  = 6'h00;
   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_JAL    = 6'h03;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNE    = 6'h05;
   localparam logic [5:0] OP_BLEZ   = 6'h06;
   localparam logic [5:0] OP_BGTZ   = 6'h07;
   localparam logic [5:0] OP_ADDI   = 6'h08;
   localparam logic [5:0] OP_ADDIU  = 6'h09;
   localparam logic [5:0] OP_SLTI   = 6'h0A;
   localparam logic [5:0] OP_SLTIU  = 6'h0B;
   localparam logic [5:0] OP_ANDI   = 6'h0C;
   localparam logic [5:0] OP_ORI    = 6'h0D;
   localparam logic [5:0] OP_XORI   = 6'h0E;
   localparam logic [5:0] OP_LUI    = 6'h0F;
   localparam logic [5:0] OP_LB     = 6'h20;
   localparam logic [5:0] OP_LH     = 6'h21;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] OP_LBU    = 6'h24;
   localparam logic [5:0] OP_LHU    = 6'h25;
   localparam logic [5:0] OP_SB     = 6'h28;
   localparam logic [5:0] OP_SH     = 6'h29;
   localparam logic [5:0] OP_SW     = 6'h2B;

   localparam logic [5:0] F_SLL   = 6'h00;
   localparam logic [5:0] F_SRL   = 6'h02;
   localparam logic [5:0] F_SRA   = 6'h03;
   localparam logic [5:0] F_SLLV  = 6'h04;
   localparam logic [5:0] F_SRLV  = 6'h06;
   localparam logic [5:0] F_SRAV  = 6'h07;
   localparam logic [5:0] F_JR    = 6'h08;
   localparam logic [5:0] F_JALR  = 6'h09;
   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;
   localparam logic [5:0] F_ADD   = 6'h20;
   localparam logic [5:0] F_ADDU  = 6'h21;
   localparam logic [5:0] F_SUB   = 6'h22;
   localparam logic [5:0] F_SUBU  = 6'h23;
   localparam logic [5:0] F_AND   = 6'h24;
   localparam logic [5:0] F_OR    = 6'h25;
   localparam logic [5:0] F_XOR   = 6'h26;
   localparam logic [5:0] F_NOR   = 6'h27;
   localparam logic [5:0] F_SLT   = 6'h2A;
   localparam logic [5:0] F_SLTU  = 6'h2B;

   localparam logic [4:0] RT_BLTZ   = 5'h00;
   localparam logic [4:0] RT_BGEZ   = 5'h01;
   localparam logic [4:0] RT_BLTZAL = 5'h10;
   localparam logic [4:0] RT_BGEZAL = 5'h11;

   localparam logic [1:0] MEM_WORD     = 2'b00;
   localparam logic [1:0] MEM_HALFWORD = 2'b01;
   localparam logic [1:0] MEM_BYTE     = 2'b10;

   localparam int CTRL_W = 14;

   typedef struct packed {
      logic       memtoreg;
      logic       memwrite;
      logic       branch;
      logic       alusrc;
      logic       regdst;
      logic       regwrite;
      logic       jump;
      logic       regjump;
      logic       link;
      logic       hilowrite;
      logic       memsignext;
      logic [1:0] membyte;
      logic       ri;
   } ctrl_t;

   function automatic logic is_mul(input logic [5:0] op, input logic [5:0] funct);
      return (op == OP_RTYPE) && ((funct == F_MULT) || (funct == F_MULTU));
   endfunction

   function automatic logic is_div(input logic [5:0] op, input logic [5:0] funct);
      return (op == OP_RTYPE) && ((funct == F_DIV) || (funct == F_DIVU));
   endfunction

   function automatic logic is_hilo_dep(input logic [5:0] op, input logic [5:0] funct);
      return (op == OP_RTYPE) &&
             ((funct == F_MFHI) || (funct == F_MFLO) || (funct == F_MTHI) ||
              (funct == F_MTLO) || is_mul(op, funct) || is_div(op, funct));
   endfunction

endpackage

// File: rtl/decode_issue_ctrl_maindec_ri.sv
// Combinational MIPS main decoder producing the control bundle, plus
// reserved-instruction detection that suppresses all architectural writes.
module maindec_ri
   import decode_issue_ctrl_pkg::*;
#(
   parameter bit RI_EN = 1'b1
) (
   input  logic [5:0]        op,
   input  logic [4:0]        rt,
   input  logic [5:0]        funct,
   output logic [CTRL_W-1:0] ctrl
);

   ctrl_t c;
   logic  ri;

   always_comb begin
      c            = '0;
      c.memsignext = 1'b1;
      c.membyte    = MEM_WORD;
      ri           = 1'b0;
      case (op)
         OP_RTYPE: begin
            c.regdst   = 1'b1;
            c.regwrite = 1'b1;
            case (funct)
               F_JR: begin
                  c.regwrite = 1'b0;
                  c.regjump  = 1'b1;
               end
               F_JALR: begin
                  c.regjump = 1'b1;
                  c.link    = 1'b1;
               end
               F_MTHI, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                  c.regwrite  = 1'b0;
                  c.hilowrite = 1'b1;
               end
               F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV, F_MFHI, F_MFLO,
               F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
               F_SLT, F_SLTU: begin
               end
               default: ri = 1'b1;
            endcase
         end
         OP_REGIMM: begin
            c.branch = 1'b1;
            case (rt)
               RT_BLTZ, RT_BGEZ: begin
               end
               RT_BLTZAL, RT_BGEZAL: begin
                  c.link     = 1'b1;
                  c.regwrite = 1'b1;
               end
               default: ri = 1'b1;
            endcase
         end
         OP_J:   c.jump = 1'b1;
         OP_JAL: begin
            c.jump     = 1'b1;
            c.link     = 1'b1;
            c.regwrite = 1'b1;
         end
         OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: c.branch = 1'b1;
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
            c.alusrc   = 1'b1;
            c.regwrite = 1'b1;
         end
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
            c.memtoreg = 1'b1;
            c.alusrc   = 1'b1;
            c.regwrite = 1'b1;
            if (op == OP_LB || op == OP_LBU) c.membyte = MEM_BYTE;
            if (op == OP_LH || op == OP_LHU) c.membyte = MEM_HALFWORD;
            if (op == OP_LBU || op == OP_LHU) c.memsignext = 1'b0;
         end
         OP_SB, OP_SH, OP_SW: begin
            c.memwrite = 1'b1;
            c.alusrc   = 1'b1;
            if (op == OP_SB) c.membyte = MEM_BYTE;
            if (op == OP_SH) c.membyte = MEM_HALFWORD;
         end
         default: ri = 1'b1;
      endcase
      // A reserved instruction must not change any architectural state.
      if (RI_EN && ri) begin
         c.regwrite  = 1'b0;
         c.memwrite  = 1'b0;
         c.hilowrite = 1'b0;
         c.branch    = 1'b0;
         c.jump      = 1'b0;
         c.ri        = 1'b1;
      end
   end

   assign ctrl = c;

endmodule

// File: rtl/decode_issue_ctrl.sv
// ID/EX issue stage: decodes the ID instruction, holds the control bundle behind
// a valid/ready handshake with flush, and stalls HI/LO users while HI/LO is busy.
module decode_issue_ctrl
   import decode_issue_ctrl_pkg::*;
#(
   parameter int MUL_LATENCY = 2,
   parameter int DIV_LATENCY = 8,
   parameter bit RI_EN       = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [31:0] id_instr,
   output logic        id_ready,
   input  logic        flush,
   input  logic        ex_ready,
   output logic        ex_valid,
   output logic [31:0] ex_instr,
   output logic        ex_memtoreg,
   output logic        ex_memwrite,
   output logic        ex_branch,
   output logic        ex_alusrc,
   output logic        ex_regdst,
   output logic        ex_regwrite,
   output logic        ex_jump,
   output logic        ex_regjump,
   output logic        ex_link,
   output logic        ex_hilowrite,
   output logic        ex_memsignext,
   output logic [1:0]  ex_membyte,
   output logic        ex_ri,
   output logic        hilo_busy
);

   localparam logic [5:0] MUL_LAT = 6'(MUL_LATENCY);
   localparam logic [5:0] DIV_LAT = 6'(DIV_LATENCY);

   logic [CTRL_W-1:0] dec_ctrl;
   ctrl_t             ex_ctrl;
   logic              space, accept, leave, hilo_dep;
   logic [5:0]        busy_cnt, busy_cnt_next;

   maindec_ri #(.RI_EN(RI_EN)) u_maindec (
      .op    (id_instr[31:26]),
      .rt    (id_instr[20:16]),
      .funct (id_instr[5:0]),
      .ctrl  (dec_ctrl)
   );

   // Handshake: a bundle moves ID->EX when id_valid && id_ready, and leaves EX
   // when ex_valid && ex_ready; flush kills the slot and blocks acceptance.
   assign hilo_dep = is_hilo_dep(id_instr[31:26], id_instr[5:0]);
   assign space    = !ex_valid || ex_ready;
   assign id_ready = space && !(hilo_dep && hilo_busy) && !flush;
   assign accept   = id_valid && id_ready;
   assign leave    = ex_valid && ex_ready && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid           <= 1'b0;
         ex_instr           <= '0;
         ex_ctrl            <= '0;
         ex_ctrl.memsignext <= 1'b1;
         ex_ctrl.membyte    <= MEM_WORD;
      end else if (flush) begin
         ex_valid <= 1'b0;
      end else if (accept) begin
         ex_valid <= 1'b1;
         ex_instr <= id_instr;
         ex_ctrl  <= ctrl_t'(dec_ctrl);
      end else if (ex_ready) begin
         ex_valid <= 1'b0;
      end
   end

   // The busy window starts when the multi-cycle op leaves EX, not while it waits.
   always_comb begin
      busy_cnt_next = busy_cnt;
      if (leave && is_mul(ex_instr[31:26], ex_instr[5:0]))
         busy_cnt_next = MUL_LAT;
      else if (leave && is_div(ex_instr[31:26], ex_instr[5:0]))
         busy_cnt_next = DIV_LAT;
      else if (busy_cnt != 6'd0)
         busy_cnt_next = busy_cnt - 6'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_cnt  <= '0;
         hilo_busy <= 1'b0;
      end else begin
         busy_cnt  <= busy_cnt_next;
         hilo_busy <= (busy_cnt_next != 6'd0);
      end
   end

   assign ex_memtoreg   = ex_ctrl.memtoreg;
   assign ex_memwrite   = ex_ctrl.memwrite;
   assign ex_branch     = ex_ctrl.branch;
   assign ex_alusrc     = ex_ctrl.alusrc;
   assign ex_regdst     = ex_ctrl.regdst;
   assign ex_regwrite   = ex_ctrl.regwrite;
   assign ex_jump       = ex_ctrl.jump;
   assign ex_regjump    = ex_ctrl.regjump;
   assign ex_link       = ex_ctrl.link;
   assign ex_hilowrite  = ex_ctrl.hilowrite;
   assign ex_memsignext = ex_ctrl.memsignext;
   assign ex_membyte    = ex_ctrl.membyte;
   assign ex_ri         = ex_ctrl.ri;

endmodule
